// File: rtl/aes_pkg.sv
// Shared constants, types and helpers for the iterative AES-128 key scheduler.
package aes_pkg;

   localparam int unsigned NK     = 4;
   localparam int unsigned NR     = 10;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned KEY_W  = NK * WORD_W;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned BYTE_W = 8;

   localparam logic [BYTE_W-1:0] RCON_INIT = 8'h01;

   typedef logic [WORD_W-1:0] aes_word_t;

   // Round key as four words, w0 in the most significant position (FIPS-197 byte order)
   typedef struct packed {
      aes_word_t w0;
      aes_word_t w1;
      aes_word_t w2;
      aes_word_t w3;
   } rk_words_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ks_state_t;

   function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box as a combinational 256-entry ROM.
module aes_sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_sub_c
);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign o_sub_c = SBOX[i_byte];

endmodule

// File: rtl/aes_subword.sv
// SubWord: byte-wise S-box substitution of one 32-bit word, purely combinational.
module aes_subword
   import aes_pkg::*;
(
   input  aes_word_t i_word,
   output aes_word_t o_word_c
);

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
         .i_byte  (i_word[g*8 +: 8]),
         .o_sub_c (o_word_c[g*8 +: 8])
      );
   end

endmodule

// File: rtl/aes_key_sched_seq.sv
// Iterative AES-128 key scheduler: emits round keys 0..10 one per valid/ready transfer,
// computing each next key on the fly from the registered current key.
module aes_key_sched_seq
   import aes_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             kld,
   input  logic [KEY_W-1:0] key,
   output logic [KEY_W-1:0] rk,
   output logic [IDX_W-1:0] rk_idx,
   output logic             rk_valid,
   input  logic             rk_ready,
   output logic             busy,
   output logic             done
);

   ks_state_t         r_state;
   ks_state_t         w_state_nxt;
   rk_words_t         r_rk;
   rk_words_t         w_rk_nxt;
   rk_words_t         w_rk_step;
   logic [IDX_W-1:0]  r_idx;
   logic [IDX_W-1:0]  w_idx_nxt;
   logic              r_valid;
   logic              w_valid_nxt;
   logic              r_busy;
   logic              w_busy_nxt;
   logic              r_done;
   logic              w_done_nxt;
   logic [BYTE_W-1:0] r_rcon;
   logic [BYTE_W-1:0] w_rcon_nxt;

   aes_word_t         w_rot;
   aes_word_t         w_sub;
   aes_word_t         w_t;
   logic              w_xfer;
   logic              w_last;

   // RotWord then SubWord on w3: the single S-box level between registers
   assign w_rot = {r_rk.w3[23:0], r_rk.w3[31:24]};

   aes_subword u_subword (
      .i_word   (w_rot),
      .o_word_c (w_sub)
   );

   assign w_t          = w_sub ^ {r_rcon, 24'h0};
   assign w_rk_step.w0 = r_rk.w0 ^ w_t;
   assign w_rk_step.w1 = r_rk.w1 ^ w_rk_step.w0;
   assign w_rk_step.w2 = r_rk.w2 ^ w_rk_step.w1;
   assign w_rk_step.w3 = r_rk.w3 ^ w_rk_step.w2;

   assign w_xfer = r_valid && rk_ready;
   assign w_last = (r_idx == IDX_W'(NR));

   always_comb begin
      w_state_nxt = r_state;
      w_rk_nxt    = r_rk;
      w_idx_nxt   = r_idx;
      w_valid_nxt = r_valid;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_rcon_nxt  = r_rcon;

      case (r_state)
         IDLE: begin
            if (kld) begin
               w_rk_nxt    = rk_words_t'(key);
               w_idx_nxt   = '0;
               w_valid_nxt = 1'b1;
               w_busy_nxt  = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (w_xfer) begin
               if (w_last) begin
                  // rk keeps the round-10 key after the stream ends
                  w_valid_nxt = 1'b0;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_rcon_nxt  = RCON_INIT;
                  w_state_nxt = IDLE;
               end else begin
                  w_rk_nxt    = w_rk_step;
                  w_idx_nxt   = r_idx + IDX_W'(1);
                  w_rcon_nxt  = xtime(r_rcon);
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_rk    <= '0;
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_rcon  <= RCON_INIT;
      end else begin
         r_state <= w_state_nxt;
         r_rk    <= w_rk_nxt;
         r_idx   <= w_idx_nxt;
         r_valid <= w_valid_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_rcon  <= w_rcon_nxt;
      end
   end

   assign rk       = KEY_W'(r_rk);
   assign rk_idx   = r_idx;
   assign rk_valid = r_valid;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Self-checking bench for aes_key_sched_seq against a GF(2^8)-arithmetic key expansion model.
module tb_aes_key_sched_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic         kld;
   logic [127:0] key;
   logic [127:0] rk;
   logic [3:0]   rk_idx;
   logic         rk_valid;
   logic         rk_ready;
   logic         busy;
   logic         done;

   int errors = 0;
   int checks = 0;

   logic [127:0] m_exp [11];
   logic [127:0] cap   [11];

   localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   aes_key_sched_seq dut (
      .clk      (clk),
      .rst      (rst),
      .kld      (kld),
      .key      (key),
      .rk       (rk),
      .rk_idx   (rk_idx),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   // S-box from its definition: multiplicative inverse (x^254) then affine map
   function automatic logic [7:0] sbox_ref(input logic [7:0] x);
      logic [7:0] inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      if (x == 8'h00) inv = 8'h00;
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   task automatic expand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_ref(tmp[31:24]), sbox_ref(tmp[23:16]),
                   sbox_ref(tmp[15:8]),  sbox_ref(tmp[7:0])} ^ {rc, 24'h0};
            rc  = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++) m_exp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Load k, drain all 11 keys (optionally with random backpressure and a stray kld at idx5),
   // checking every transfer, stall stability, busy/done and the cycle count to done.
   task automatic run_seq(input logic [127:0] k, input bit bp, input bit inject,
                          input string tag, output int n_cyc);
      int          got = 0;
      bit          prev_stall = 0;
      bit          injected = 0;
      logic [127:0] prev_rk = '0;
      logic [3:0]  prev_idx = '0;
      expand(k);
      kld = 1'b1;
      key = k;
      step();
      kld = 1'b0;
      key = {$urandom, $urandom, $urandom, $urandom};
      rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      n_cyc = 1;
      while (!done && n_cyc < 200) begin
         checks++;
         if (rk_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s valid_busy cyc=%0d: got valid=%b busy=%b exp 1 1", tag, n_cyc, rk_valid, busy);
         end
         if (prev_stall) begin
            checks++;
            if (rk !== prev_rk || rk_idx !== prev_idx) begin
               errors++;
               $display("FAIL %s stall_hold: got %h/%0d exp %h/%0d", tag, rk, rk_idx, prev_rk, prev_idx);
            end
         end
         if (rk_valid && rk_ready && got < 11) begin
            checks++;
            if (rk_idx !== 4'(got) || rk !== m_exp[got]) begin
               errors++;
               $display("FAIL %s key%0d: got idx=%0d rk=%h exp idx=%0d rk=%h", tag, got, rk_idx, rk, got, m_exp[got]);
            end
            cap[got] = rk;
            got++;
         end
         prev_stall = rk_valid && !rk_ready;
         prev_rk    = rk;
         prev_idx   = rk_idx;
         if (inject && !injected && rk_idx == 4'd5) begin
            kld = 1'b1;
            key = ~k;
            injected = 1;
         end
         step();
         kld = 1'b0;
         rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         n_cyc++;
      end
      checks++;
      if (done !== 1'b1 || got != 11 || busy !== 1'b0 || rk_valid !== 1'b0 || rk !== m_exp[10]) begin
         errors++;
         $display("FAIL %s end: got done=%b n=%0d busy=%b valid=%b rk=%h exp 1 11 0 0 %h",
                  tag, done, got, busy, rk_valid, rk, m_exp[10]);
      end
      rk_ready = 1'b1;
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s done_pulse: got done=%b busy=%b exp 0 0", tag, done, busy);
      end
   endtask

   task automatic check_zero(input string tag);
      checks++;
      if (rk !== '0 || rk_idx !== 4'd0 || rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s: got rk=%h idx=%0d valid=%b busy=%b done=%b exp all 0",
                  tag, rk, rk_idx, rk_valid, busy, done);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; kld = 1'b0; key = '0; rk_ready = 1'b0;
      step();
      step();
      check_zero("reset_state");
      rst = 1'b0;
      step();
      check_zero("idle_hold");
   endtask

   task automatic test_fips();
      int n;
      run_seq(FIPS_KEY, 0, 0, "fips", n);
      checks++;
      if (cap[0] !== FIPS_KEY || cap[1] !== FIPS_RK1 || cap[10] !== FIPS_RK10) begin
         errors++;
         $display("FAIL fips_vectors: got %h %h %h", cap[0], cap[1], cap[10]);
      end
      checks++;
      if (n != 12) begin
         errors++;
         $display("FAIL fips_done_latency: got %0d exp 12", n);
      end
   endtask

   task automatic test_zero_key();
      int n;
      run_seq('0, 0, 0, "zero", n);
      checks++;
      if (cap[1] !== ZERO_RK1 || cap[10] !== ZERO_RK10) begin
         errors++;
         $display("FAIL zero_vectors: got %h %h exp %h %h", cap[1], cap[10], ZERO_RK1, ZERO_RK10);
      end
   endtask

   task automatic test_backpressure();
      int n;
      run_seq(FIPS_KEY, 1, 0, "bp_fips", n);
      checks++;
      if (cap[1] !== FIPS_RK1 || cap[10] !== FIPS_RK10) begin
         errors++;
         $display("FAIL bp_vectors: got %h %h exp %h %h", cap[1], cap[10], FIPS_RK1, FIPS_RK10);
      end
      for (int i = 0; i < 3; i++)
         run_seq({$urandom, $urandom, $urandom, $urandom}, 1, 0, "bp_rand", n);
   endtask

   task automatic test_kld_ignored();
      int n;
      logic [127:0] k2;
      run_seq(FIPS_KEY, 0, 1, "kld_in_run", n);
      k2 = {$urandom, $urandom, $urandom, $urandom};
      run_seq(k2, 0, 0, "reload", n);
   endtask

   task automatic test_back_to_back();
      int n;
      // new kld in the done cycle must be accepted
      expand(FIPS_KEY);
      kld = 1'b1; key = FIPS_KEY; rk_ready = 1'b1;
      step();
      kld = 1'b0;
      for (int i = 0; i < 10 && !done; i++) step();
      step();
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_done: got %b exp 1", done);
      end
      kld = 1'b1; key = 128'h000102030405060708090a0b0c0d0e0f;
      step();
      kld = 1'b0;
      expand(128'h000102030405060708090a0b0c0d0e0f);
      checks++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'd0 || rk !== m_exp[0]) begin
         errors++;
         $display("FAIL b2b_reload: got valid=%b idx=%0d rk=%h exp 1 0 %h", rk_valid, rk_idx, rk, m_exp[0]);
      end
      for (int i = 0; i < 12 && !done; i++) step();
      step();
      n = 0;
   endtask

   task automatic test_rst_mid();
      int n;
      int guard = 0;
      kld = 1'b1; key = FIPS_KEY; rk_ready = 1'b1;
      step();
      kld = 1'b0;
      while (rk_idx != 4'd4 && guard < 20) begin
         step();
         guard++;
      end
      checks++;
      if (rk_idx !== 4'd4) begin
         errors++;
         $display("FAIL rst_mid_reach: got idx=%0d exp 4", rk_idx);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_zero("rst_mid");
      step();
      check_zero("rst_mid_idle");
      run_seq(FIPS_KEY, 0, 0, "after_rst", n);
      checks++;
      if (cap[1] !== FIPS_RK1 || cap[10] !== FIPS_RK10 || n != 12) begin
         errors++;
         $display("FAIL after_rst_vectors: got %h %h n=%0d", cap[1], cap[10], n);
      end
   endtask

   task automatic test_rst_kld();
      rst = 1'b1; kld = 1'b1; key = FIPS_KEY;
      step();
      rst = 1'b0; kld = 1'b0;
      check_zero("rst_kld");
      step();
      check_zero("rst_kld_next");
   endtask

   initial begin
      rst = 1'b1; kld = 1'b0; key = '0; rk_ready = 1'b1;
      test_reset();
      test_fips();
      test_zero_key();
      test_backpressure();
      test_kld_ignored();
      test_back_to_back();
      test_rst_mid();
      test_rst_kld();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/aes_key_sched_seq.md
# aes_key_sched_seq

Iterative AES-128 key scheduler: it accepts one 128-bit cipher key and emits the 11 round keys (round 0..10) one per handshake. It sits directly upstream of the cipher round datapath, which consumes each round key. It reuses the byte S-box ROM (`aes_sbox`, four instances) for SubWord, so round keys are generated on the fly instead of being stored.

## Interface
Parameters:
- none; AES-128 only. Nk=4, Nr=10 are fixed constants in the package.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `kld` in 1: key-load strobe; sampled only while idle.
- `key` in 128: cipher key, FIPS-197 byte order, `key[127:120]` = byte 0; sampled in the `kld` cycle.
- `rk` out 128: current round key, same byte order.
- `rk_idx` out 4: round number of `rk`, 0..10.
- `rk_valid` out 1: `rk`/`rk_idx` are valid.
- `rk_ready` in 1: consumer accepts; a transfer occurs when `rk_valid && rk_ready`.
- `busy` out 1: high from the cycle after an accepted `kld` until the last transfer completes.
- `done` out 1: one-cycle pulse after the round-10 transfer.

## Operation
- State register with two states, IDLE and RUN. Reset state is IDLE.
- Reset values: `rk`=0, `rk_idx`=0, `rk_valid`=0, `busy`=0, `done`=0, internal rcon=8'h01.
- IDLE:
  - `kld`=1 loads the key words w0..w3 from `key` into `rk`, sets `rk_idx`=0, `rk_valid`=1, `busy`=1, and moves to RUN.
  - `kld`=0: hold.
- RUN:
  - While `rk_valid && !rk_ready`, `rk` and `rk_idx` stay stable; no other state changes.
  - On a transfer with `rk_idx`<10:
    - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
    - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'
    - `rk_idx` increments by 1; rcon' = xtime(rcon), so 8'h80 goes to 8'h1b.
    - `rk_valid` stays 1.
  - On a transfer with `rk_idx`=10: `rk_valid`=0, `busy`=0, `done`=1 for one cycle, rcon returns to 8'h01, and the state goes to IDLE. `rk` holds its last value.
- `kld` is ignored while in RUN; there is no restart and no abort except `rst`.
- Simultaneous `kld` and `rst`: `rst` wins.
- `rst` in the middle of RUN: the next cycle matches the reset state and any partially emitted sequence is abandoned.
- `rk_ready` is ignored while `rk_valid`=0.
- SubWord is purely combinational, from the registered w3 through four S-boxes. The next key is registered, so there is exactly one S-box level per cycle.

## Timing
- `kld` accepted at edge t: the round-0 key is valid from cycle t+1.
- Each transfer at edge n: the next round key is valid in cycle n+1, giving a zero-bubble stream.
- With `rk_ready` held high: `rk_idx` runs 0..10 in cycles t+1..t+11, `done`=1 in cycle t+12, and a new `kld` is accepted in cycle t+12.
- `done` and `busy` never overlap. `rk_valid` implies `busy`.

## Structure
- Package `aes_pkg`:
  - `NR`=10
  - `RCON_INIT`=8'h01
  - `xtime` function
  - state enum type `ks_state_t` {IDLE, RUN}
  - 32-bit word typedef `aes_word_t`
- Sub-module `aes_subword`: 32-bit in/out, four `aes_sbox` instances, combinational. It is instanced once inside `aes_key_sched_seq`.

## Test plan
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1:
   - idx0 = the key itself
   - idx1 = a0fafe1788542cb123a339392a6c7605
   - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6
   - `done` appears exactly 12 cycles after `kld`.
2. All-zero key:
   - idx1 = 62636363626363636263636362636363
   - idx10 = b4ef5bcb3e92e21123e951cf6f8f188e
   - confirms the rcon wrap 8'h80 to 8'h1b.
3. Backpressure:
   - randomly toggle `rk_ready` with the case-1 key.
   - `rk`/`rk_idx` stay stable while stalled, and the 11 accepted keys match case 1 in order.
4. Pulse `kld` with a different key at idx5 during RUN:
   - it is ignored and the sequence finishes with the original key values.
   - then `kld` again in IDLE and check that idx1 is correct for the new key, i.e. rcon was reset.
5. Assert `rst` at idx4:
   - next cycle all outputs are 0 and the state is IDLE.
   - a subsequent `kld` of the case-1 key reproduces case 1 exactly.
6. `kld` and `rst` asserted in the same cycle: no load occurs and `rk_valid` stays 0.
